// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM request bus and MEM-stage responses for mem_access_stage.
// master = pipeline side (drives the request), slave = memory stage.
interface mem_access_stage_if;
  logic        EX_MEM_mem_read;
  logic        EX_MEM_we_dm;
  logic [1:0]  EX_MEM_size;
  logic        EX_MEM_load_unsigned;
  logic [31:0] EX_MEM_alu_pa;
  logic [31:0] EX_MEM_wd_dm;
  logic [31:0] rd_dm;
  logic        mem_stall;
  logic        misalign_exc;

  modport master (
    output EX_MEM_mem_read, EX_MEM_we_dm, EX_MEM_size, EX_MEM_load_unsigned,
           EX_MEM_alu_pa, EX_MEM_wd_dm,
    input  rd_dm, mem_stall, misalign_exc
  );

  modport slave (
    input  EX_MEM_mem_read, EX_MEM_we_dm, EX_MEM_size, EX_MEM_load_unsigned,
           EX_MEM_alu_pa, EX_MEM_wd_dm,
    output rd_dm, mem_stall, misalign_exc
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage data memory: word/half/byte loads and stores with LATENCY extra wait cycles.
// Optional access/stall counters enabled by defining MEM_ACCESS_CNT_EN.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input logic              clk,
  input logic              rst,
  mem_access_stage_if.slave bus
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [31:0]      load_cnt,
  output logic [31:0]      store_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [2:0] LAT_M1 = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  logic [1:0]    r_state;
  logic [2:0]    r_cnt;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [1:0]    w_off;
  logic [AW-1:0] w_idx;
  logic          w_is_half, w_is_byte, w_is_word;
  logic          w_req, w_store, w_load;
  logic          w_misalign, w_valid, w_complete, w_stall;
  logic [2:0]    w_cnt_dec;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_word, w_sh, w_ldata;
  logic          w_unused;

  assign w_unused = ^bus.EX_MEM_alu_pa[31:AW+2];

  always_comb begin
    w_off     = bus.EX_MEM_alu_pa[1:0];
    w_idx     = bus.EX_MEM_alu_pa[AW+1:2];
    w_is_half = (bus.EX_MEM_size == 2'b01);
    w_is_byte = (bus.EX_MEM_size == 2'b10);
    w_is_word = !w_is_half && !w_is_byte;
    w_store   = bus.EX_MEM_we_dm;
    w_load    = bus.EX_MEM_mem_read && !bus.EX_MEM_we_dm;
    w_req     = bus.EX_MEM_mem_read || bus.EX_MEM_we_dm;
    w_misalign = w_req && ((w_is_word && (w_off != 2'b00)) || (w_is_half && w_off[0]));
    w_valid    = w_req && !w_misalign;
    // Outputs and RAM writes are masked while rst is high so a held request cannot leak through.
    w_complete = !rst && w_valid && ((LATENCY == 0) || (r_state == S_DONE));
    w_stall    = !rst && (LATENCY != 0) &&
                 (((r_state == S_IDLE) && w_valid) || (r_state == S_WAIT));
    w_cnt_dec  = r_cnt - 3'd1;
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.EX_MEM_wd_dm;
    if (w_is_half) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{bus.EX_MEM_wd_dm[15:0]}};
    end else if (w_is_byte) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{bus.EX_MEM_wd_dm[7:0]}};
    end
  end

  always_comb begin
    w_word  = r_mem[w_idx];
    w_sh    = w_word >> {w_off, 3'b000};
    w_ldata = w_word;
    if (w_is_byte)
      w_ldata = bus.EX_MEM_load_unsigned ? {24'd0, w_sh[7:0]} : {{24{w_sh[7]}}, w_sh[7:0]};
    else if (w_is_half)
      w_ldata = bus.EX_MEM_load_unsigned ? {16'd0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
  end

  assign bus.rd_dm        = (w_complete && w_load) ? w_ldata : '0;
  assign bus.mem_stall    = w_stall;
  assign bus.misalign_exc = !rst && w_misalign && (r_state == S_IDLE);

  // r_cnt holds the WAIT cycles still to go; DONE is entered when the decrement reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (LATENCY != 0) begin
      case (r_state)
        S_IDLE: if (w_valid) begin
          r_cnt   <= LAT_M1;
          r_state <= (LATENCY > 1) ? S_WAIT : S_DONE;
        end
        S_WAIT: begin
          r_cnt <= w_cnt_dec;
          if (w_cnt_dec == 3'd0) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_complete && w_store) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

`ifdef MEM_ACCESS_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_complete && w_load && (load_cnt != '1))   load_cnt  <= load_cnt + 32'd1;
      if (w_complete && w_store && (store_cnt != '1)) store_cnt <= store_cnt + 32'd1;
      if (w_stall && (stall_cnt != '1))               stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: three instances with LATENCY 0, 2 and 3.
// Counter checks are compiled in when MEM_ACCESS_CNT_EN is defined.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        t_mr [3];
  logic        t_we [3];
  logic [1:0]  t_sz [3];
  logic        t_uns[3];
  logic [31:0] t_pa [3];
  logic [31:0] t_wd [3];
  logic [31:0] o_rd [3];
  logic        o_st [3];
  logic        o_mis[3];
`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] lc[3], sc[3], stc[3];
`endif

  mem_access_stage_if bus[3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].EX_MEM_mem_read      = t_mr[g];
    assign bus[g].EX_MEM_we_dm         = t_we[g];
    assign bus[g].EX_MEM_size          = t_sz[g];
    assign bus[g].EX_MEM_load_unsigned = t_uns[g];
    assign bus[g].EX_MEM_alu_pa        = t_pa[g];
    assign bus[g].EX_MEM_wd_dm         = t_wd[g];
    assign o_rd[g]  = bus[g].rd_dm;
    assign o_st[g]  = bus[g].mem_stall;
    assign o_mis[g] = bus[g].misalign_exc;

    mem_access_stage #(.DEPTH_WORDS(256), .LATENCY((g == 0) ? 0 : g + 1)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus[g])
`ifdef MEM_ACCESS_CNT_EN
      ,
      .load_cnt(lc[g]),
      .store_cnt(sc[g]),
      .stall_cnt(stc[g])
`endif
    );
  end

  typedef struct {
    int          d;
    logic        rd, we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a, wd;
    logic [31:0] e_rd;
    int          e_st;
    logic        e_mis;
  } stim_t;

  typedef struct {
    logic [31:0] rd;
    int          st;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic stim_t mk(int d, bit rd, bit we, logic [1:0] sz, bit uns,
                               logic [31:0] a, logic [31:0] wd,
                               logic [31:0] e_rd, int e_st, bit e_mis);
    stim_t s;
    s.d = d; s.rd = rd; s.we = we; s.sz = sz; s.uns = uns; s.a = a; s.wd = wd;
    s.e_rd = e_rd; s.e_st = e_st; s.e_mis = e_mis;
    return s;
  endfunction

  task automatic clear(input int d);
    t_mr[d] = 0; t_we[d] = 0; t_sz[d] = 0; t_uns[d] = 0; t_pa[d] = 0; t_wd[d] = 0;
  endtask

  // Drives one request and holds it until the DUT stops stalling (bounded).
  task automatic access(input stim_t s, output logic [31:0] r, output int st,
                        output logic m, output bit to);
    @(posedge clk); #1;
    t_mr[s.d] = s.rd; t_we[s.d] = s.we; t_sz[s.d] = s.sz; t_uns[s.d] = s.uns;
    t_pa[s.d] = s.a;  t_wd[s.d] = s.wd;
    st = 0; to = 1; r = 'x; m = 'x;
    for (int c = 0; c < 20 && to; c++) begin
      @(negedge clk);
      if (o_st[s.d]) st++;
      else begin r = o_rd[s.d]; m = o_mis[s.d]; to = 0; end
    end
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    clear(d);
  endtask

  task automatic test_reset();
    rst = 1;
    for (int d = 0; d < 3; d++) begin
      t_mr[d] = 1; t_we[d] = 1; t_sz[d] = 0; t_uns[d] = 0; t_pa[d] = 32'h10; t_wd[d] = 32'hFFFF_FFFF;
    end
    @(negedge clk); @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks += 3;
      if (o_rd[d] === 32'd0) n_pass++; else $display("FAIL reset_rd[%0d] got %h want 00000000", d, o_rd[d]);
      if (o_st[d] === 1'b0) n_pass++; else $display("FAIL reset_stall[%0d] got %b want 0", d, o_st[d]);
      if (o_mis[d] === 1'b0) n_pass++; else $display("FAIL reset_mis[%0d] got %b want 0", d, o_mis[d]);
      clear(d);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_lat0();
    stim_t t[$];
    exp_t e; logic [31:0] r; int st; logic m; bit to;
    t.push_back(mk(0, 0, 1, 2'd0, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 0));
    t.push_back(mk(0, 1, 0, 2'd0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0));
    t.push_back(mk(0, 0, 1, 2'd0, 0, 32'h14, 32'h1122_3344, 32'h0, 0, 0));
    t.push_back(mk(0, 1, 0, 2'd2, 1, 32'h15, 32'h0, 32'h0000_0033, 0, 0));
    foreach (t[i]) begin
      sb.push_back('{t[i].e_rd, t[i].e_st, t[i].e_mis});
      access(t[i], r, st, m, to);
      e = sb.pop_front();
      n_checks += 3;
      if (!to && r === e.rd) n_pass++; else $display("FAIL lat0_rd[%0d] got %h want %h timeout=%0d", i, r, e.rd, to);
      if (st == e.st) n_pass++; else $display("FAIL lat0_stall[%0d] got %0d want %0d", i, st, e.st);
      if (m === e.mis) n_pass++; else $display("FAIL lat0_mis[%0d] got %b want %b", i, m, e.mis);
    end
    idle(0);
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    exp_t e; logic [31:0] r; int st; logic m; bit to;
    t.push_back(mk(1, 0, 1, 2'd0, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2, 0));
    foreach (t[i]) begin
      sb.push_back('{t[i].e_rd, t[i].e_st, t[i].e_mis});
      access(t[i], r, st, m, to);
      e = sb.pop_front();
      n_checks += 3;
      if (!to && r === e.rd) n_pass++; else $display("FAIL b2b_rd[%0d] got %h want %h timeout=%0d", i, r, e.rd, to);
      if (st == e.st) n_pass++; else $display("FAIL b2b_stall[%0d] got %0d want %0d", i, st, e.st);
      if (m === e.mis) n_pass++; else $display("FAIL b2b_mis[%0d] got %b want %b", i, m, e.mis);
    end
    idle(1);
  endtask

  task automatic test_subword();
    stim_t t[$];
    exp_t e; logic [31:0] r; int st; logic m; bit to;
    t.push_back(mk(1, 0, 1, 2'd0, 0, 32'h10, 32'h0000_0000, 32'h0, 2, 0));
    t.push_back(mk(1, 0, 1, 2'd2, 0, 32'h13, 32'hAAAA_AA80, 32'h0, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd2, 0, 32'h13, 32'h0, 32'hFFFF_FF80, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd2, 1, 32'h13, 32'h0, 32'h0000_0080, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd0, 0, 32'h10, 32'h0, 32'h8000_0000, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd1, 0, 32'h12, 32'h0, 32'hFFFF_8000, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd1, 1, 32'h12, 32'h0, 32'h0000_8000, 2, 0));
    t.push_back(mk(1, 0, 1, 2'd1, 0, 32'h10, 32'h5555_1234, 32'h0, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd0, 0, 32'h10, 32'h0, 32'h8000_1234, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd2, 0, 32'h11, 32'h0, 32'h0000_0012, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd3, 0, 32'h10, 32'h0, 32'h8000_1234, 2, 0));
    foreach (t[i]) begin
      sb.push_back('{t[i].e_rd, t[i].e_st, t[i].e_mis});
      access(t[i], r, st, m, to);
      e = sb.pop_front();
      n_checks += 3;
      if (!to && r === e.rd) n_pass++; else $display("FAIL subword_rd[%0d] got %h want %h timeout=%0d", i, r, e.rd, to);
      if (st == e.st) n_pass++; else $display("FAIL subword_stall[%0d] got %0d want %0d", i, st, e.st);
      if (m === e.mis) n_pass++; else $display("FAIL subword_mis[%0d] got %b want %b", i, m, e.mis);
    end
    idle(1);
  endtask

  task automatic test_misalign();
    stim_t t[$];
    exp_t e; logic [31:0] r; int st; logic m; bit to;
    t.push_back(mk(1, 1, 0, 2'd1, 0, 32'h11, 32'h0, 32'h0, 0, 1));
    t.push_back(mk(1, 0, 1, 2'd0, 0, 32'h12, 32'hFFFF_FFFF, 32'h0, 0, 1));
    t.push_back(mk(1, 1, 0, 2'd0, 0, 32'h10, 32'h0, 32'h8000_1234, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd0, 0, 32'h13, 32'h0, 32'h0, 0, 1));
    t.push_back(mk(1, 1, 1, 2'd2, 0, 32'h10, 32'h0, 32'h0, 2, 0));
    t.push_back(mk(1, 1, 0, 2'd0, 0, 32'h10, 32'h0, 32'h8000_1200, 2, 0));
    foreach (t[i]) begin
      sb.push_back('{t[i].e_rd, t[i].e_st, t[i].e_mis});
      access(t[i], r, st, m, to);
      e = sb.pop_front();
      n_checks += 3;
      if (!to && r === e.rd) n_pass++; else $display("FAIL misalign_rd[%0d] got %h want %h timeout=%0d", i, r, e.rd, to);
      if (st == e.st) n_pass++; else $display("FAIL misalign_stall[%0d] got %0d want %0d", i, st, e.st);
      if (m === e.mis) n_pass++; else $display("FAIL misalign_mis[%0d] got %b want %b", i, m, e.mis);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    stim_t t[$];
    exp_t e; logic [31:0] r; int st; logic m; bit to;
    t.push_back(mk(2, 0, 1, 2'd0, 0, 32'h20, 32'hCAFE_F00D, 32'h0, 3, 0));
    foreach (t[i]) begin
      sb.push_back('{t[i].e_rd, t[i].e_st, t[i].e_mis});
      access(t[i], r, st, m, to);
      e = sb.pop_front();
      n_checks += 2;
      if (!to && r === e.rd) n_pass++; else $display("FAIL rstmid_pre_rd got %h want %h timeout=%0d", r, e.rd, to);
      if (st == e.st) n_pass++; else $display("FAIL rstmid_pre_stall got %0d want %0d", st, e.st);
    end
    @(posedge clk); #1;
    t_we[2] = 1; t_sz[2] = 0; t_pa[2] = 32'h20; t_wd[2] = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (o_st[2] === 1'b1) n_pass++; else $display("FAIL rstmid_stall_idle got %b want 1", o_st[2]);
    @(negedge clk);
    n_checks++;
    if (o_st[2] === 1'b1) n_pass++; else $display("FAIL rstmid_stall_wait got %b want 1", o_st[2]);
    rst = 1; #1;
    n_checks++;
    if (o_st[2] === 1'b0) n_pass++; else $display("FAIL rstmid_stall_drop got %b want 0", o_st[2]);
    @(negedge clk); clear(2);
    @(negedge clk); rst = 0;
    t.delete();
    t.push_back(mk(2, 1, 0, 2'd0, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 3, 0));
    foreach (t[i]) begin
      sb.push_back('{t[i].e_rd, t[i].e_st, t[i].e_mis});
      access(t[i], r, st, m, to);
      e = sb.pop_front();
      n_checks += 2;
      if (!to && r === e.rd) n_pass++; else $display("FAIL rstmid_post_rd got %h want %h timeout=%0d", r, e.rd, to);
      if (st == e.st) n_pass++; else $display("FAIL rstmid_post_stall got %0d want %0d", st, e.st);
    end
  endtask

  task automatic test_wrap_counters();
    stim_t t[$];
    exp_t e; logic [31:0] r; int st; logic m; bit to;
    t.push_back(mk(2, 0, 1, 2'd0, 0, 32'h22, 32'hFFFF_FFFF, 32'h0, 0, 1));
    t.push_back(mk(2, 0, 1, 2'd0, 0, 32'h400, 32'h0BAD_C0DE, 32'h0, 3, 0));
    t.push_back(mk(2, 1, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0BAD_C0DE, 3, 0));
    foreach (t[i]) begin
      sb.push_back('{t[i].e_rd, t[i].e_st, t[i].e_mis});
      access(t[i], r, st, m, to);
      e = sb.pop_front();
      n_checks += 3;
      if (!to && r === e.rd) n_pass++; else $display("FAIL wrap_rd[%0d] got %h want %h timeout=%0d", i, r, e.rd, to);
      if (st == e.st) n_pass++; else $display("FAIL wrap_stall[%0d] got %0d want %0d", i, st, e.st);
      if (m === e.mis) n_pass++; else $display("FAIL wrap_mis[%0d] got %b want %b", i, m, e.mis);
    end
    idle(2);
`ifdef MEM_ACCESS_CNT_EN
    n_checks += 4;
    if (lc[2] === 32'd2) n_pass++; else $display("FAIL cnt_load got %0d want 2", lc[2]);
    if (sc[2] === 32'd1) n_pass++; else $display("FAIL cnt_store got %0d want 1", sc[2]);
    if (stc[2] === 32'd9) n_pass++; else $display("FAIL cnt_stall got %0d want 9", stc[2]);
    if (sc[1] === 32'd0) n_pass++; else $display("FAIL cnt_store_idle_dut got %0d want 0", sc[1]);
`endif
  endtask

  initial begin
    for (int d = 0; d < 3; d++) clear(d);
    test_reset();
    test_lat0();
    test_back_to_back();
    test_subword();
    test_misalign();
    test_reset_mid();
    test_wrap_counters();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
